// File: rtl/hr_bridge_param_if.sv
// hr_bridge_param_if
//    Bundles the ring slot buses and status outputs of the hierarchical-ring
//    bridge so that the bridge and its environment connect through one port.
//    Signals:
//       loc_i / loc_o     local ring slots in / out, channel c at [c*FLIT_W +: FLIT_W]
//       glb_i / glb_o     global ring slots in / out, same packing
//       l2g_cnt_o         local->global FIFO occupancy, CNT_W bits per channel
//       g2l_cnt_o         global->local FIFO occupancy, CNT_W bits per channel
//       defl_l_o          saturating count of deflected local flits
//       defl_g_o          saturating count of deflected global flits
//    Modports:
//       master            ring side: drives arriving slots, observes the rest
//       slave             bridge side
interface hr_bridge_param_if #(
   parameter int FLIT_W = 144,
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [NUM_CH*FLIT_W-1:0] loc_i;
   logic [NUM_CH*FLIT_W-1:0] loc_o;
   logic [NUM_CH*FLIT_W-1:0] glb_i;
   logic [NUM_CH*FLIT_W-1:0] glb_o;
   logic [NUM_CH*CNT_W-1:0]  l2g_cnt_o;
   logic [NUM_CH*CNT_W-1:0]  g2l_cnt_o;
   logic [15:0]              defl_l_o;
   logic [15:0]              defl_g_o;

   modport master (
      output loc_i, glb_i,
      input  loc_o, glb_o, l2g_cnt_o, g2l_cnt_o, defl_l_o, defl_g_o
   );

   modport slave (
      input  loc_i, glb_i,
      output loc_o, glb_o, l2g_cnt_o, g2l_cnt_o, defl_l_o, defl_g_o
   );
endinterface

// File: rtl/hr_bridge_param.sv
// hr_bridge_param
//    Bridge between one local ring and one global ring with NUM_CH parallel
//    channels per ring. Per channel, flits that must change rings are ejected
//    into a transfer FIFO and later injected into a free slot of the other
//    ring. When the FIFO is full the flit stays on its ring (deflection) and
//    is counted.
//    Ports:
//       clk     rising-edge clock
//       rst     synchronous active-high reset
//       bus     hr_bridge_param_if.slave (ring slots, FIFO counts, deflection counts)
module hr_bridge_param #(
   parameter int FLIT_W    = 144,
   parameter int NUM_CH    = 2,
   parameter int DEPTH     = 4,
   parameter int RID_W     = 4,
   parameter int RID_LSB   = 4,
   parameter int LOCAL_RID = 0
) (
   input logic               clk,
   input logic               rst,
   hr_bridge_param_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef logic [FLIT_W-1:0] flit_t;

   flit_t             l2g_mem [NUM_CH][DEPTH];
   flit_t             g2l_mem [NUM_CH][DEPTH];
   logic [PTR_W-1:0]  l2g_wr  [NUM_CH];
   logic [PTR_W-1:0]  l2g_rd  [NUM_CH];
   logic [CNT_W-1:0]  l2g_cnt [NUM_CH];
   logic [PTR_W-1:0]  g2l_wr  [NUM_CH];
   logic [PTR_W-1:0]  g2l_rd  [NUM_CH];
   logic [CNT_W-1:0]  g2l_cnt [NUM_CH];

   logic [NUM_CH*FLIT_W-1:0] loc_q, glb_q, loc_next, glb_next;
   logic [NUM_CH-1:0]        l2g_enq, l2g_deq, g2l_enq, g2l_deq;
   logic [NUM_CH-1:0]        l_defl, g_defl;
   logic [15:0]              defl_l_q, defl_g_q, defl_l_next, defl_g_next;
   logic [16:0]              defl_l_sum, defl_g_sum;

   // Slot decisions for every channel. Full and empty tests look only at the
   // registered counts, so a dequeue never makes room for an enqueue in the
   // same cycle and a freshly enqueued flit cannot bypass to the other ring.
   always_comb begin : slot_logic
      flit_t lf, gf;
      logic  l_cross, l_free, g_cross, g_free;
      lf       = '0;
      gf       = '0;
      l_cross  = 1'b0;
      l_free   = 1'b0;
      g_cross  = 1'b0;
      g_free   = 1'b0;
      loc_next = '0;
      glb_next = '0;
      l2g_enq  = '0;
      l2g_deq  = '0;
      g2l_enq  = '0;
      g2l_deq  = '0;
      l_defl   = '0;
      g_defl   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         lf = bus.loc_i[c*FLIT_W +: FLIT_W];
         gf = bus.glb_i[c*FLIT_W +: FLIT_W];

         l_cross    = lf[0] && (lf[RID_LSB +: RID_W] != RID_W'(LOCAL_RID));
         l2g_enq[c] = l_cross && (l2g_cnt[c] != CNT_W'(DEPTH));
         l_defl[c]  = l_cross && (l2g_cnt[c] == CNT_W'(DEPTH));
         l_free     = !lf[0] || l2g_enq[c];

         g_cross    = gf[0] && (gf[RID_LSB +: RID_W] == RID_W'(LOCAL_RID));
         g2l_enq[c] = g_cross && (g2l_cnt[c] != CNT_W'(DEPTH));
         g_defl[c]  = g_cross && (g2l_cnt[c] == CNT_W'(DEPTH));
         g_free     = !gf[0] || g2l_enq[c];

         g2l_deq[c] = l_free && (g2l_cnt[c] != '0);
         l2g_deq[c] = g_free && (l2g_cnt[c] != '0);

         if (g2l_deq[c])
            loc_next[c*FLIT_W +: FLIT_W] = g2l_mem[c][g2l_rd[c]];
         else if (!l_free)
            loc_next[c*FLIT_W +: FLIT_W] = lf;

         if (l2g_deq[c])
            glb_next[c*FLIT_W +: FLIT_W] = l2g_mem[c][l2g_rd[c]];
         else if (!g_free)
            glb_next[c*FLIT_W +: FLIT_W] = gf;
      end
   end

   // Several channels may deflect in the same cycle, so the counters add the
   // number of deflections; a 17-bit sum exposes the overflow for saturation.
   always_comb begin
      defl_l_sum = {1'b0, defl_l_q};
      defl_g_sum = {1'b0, defl_g_q};
      for (int c = 0; c < NUM_CH; c++) begin
         defl_l_sum = defl_l_sum + 17'(l_defl[c]);
         defl_g_sum = defl_g_sum + 17'(g_defl[c]);
      end
      defl_l_next = defl_l_sum[16] ? 16'hFFFF : defl_l_sum[15:0];
      defl_g_next = defl_g_sum[16] ? 16'hFFFF : defl_g_sum[15:0];
   end

   // FIFO storage needs no reset: only entries inside the valid pointer
   // window are ever read.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (l2g_enq[c]) l2g_mem[c][l2g_wr[c]] <= bus.loc_i[c*FLIT_W +: FLIT_W];
         if (g2l_enq[c]) g2l_mem[c][g2l_wr[c]] <= bus.glb_i[c*FLIT_W +: FLIT_W];
      end
   end

   // Output slots, FIFO pointers/counts and deflection counters. Pointers
   // wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         loc_q    <= '0;
         glb_q    <= '0;
         defl_l_q <= '0;
         defl_g_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            l2g_wr[c]  <= '0;
            l2g_rd[c]  <= '0;
            l2g_cnt[c] <= '0;
            g2l_wr[c]  <= '0;
            g2l_rd[c]  <= '0;
            g2l_cnt[c] <= '0;
         end
      end else begin
         loc_q    <= loc_next;
         glb_q    <= glb_next;
         defl_l_q <= defl_l_next;
         defl_g_q <= defl_g_next;
         for (int c = 0; c < NUM_CH; c++) begin
            if (l2g_enq[c]) l2g_wr[c] <= l2g_wr[c] + PTR_W'(1);
            if (l2g_deq[c]) l2g_rd[c] <= l2g_rd[c] + PTR_W'(1);
            if (g2l_enq[c]) g2l_wr[c] <= g2l_wr[c] + PTR_W'(1);
            if (g2l_deq[c]) g2l_rd[c] <= g2l_rd[c] + PTR_W'(1);
            l2g_cnt[c] <= l2g_cnt[c] + CNT_W'(l2g_enq[c]) - CNT_W'(l2g_deq[c]);
            g2l_cnt[c] <= g2l_cnt[c] + CNT_W'(g2l_enq[c]) - CNT_W'(g2l_deq[c]);
         end
      end
   end

   // Pack per-channel counts onto the flat status buses.
   always_comb begin
      bus.l2g_cnt_o = '0;
      bus.g2l_cnt_o = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         bus.l2g_cnt_o[c*CNT_W +: CNT_W] = l2g_cnt[c];
         bus.g2l_cnt_o[c*CNT_W +: CNT_W] = g2l_cnt[c];
      end
   end

   assign bus.loc_o    = loc_q;
   assign bus.glb_o    = glb_q;
   assign bus.defl_l_o = defl_l_q;
   assign bus.defl_g_o = defl_g_q;
endmodule

// File: tb/tb_hr_bridge_param.sv
// tb_hr_bridge_param
//    Directed bench for hr_bridge_param with default parameters
//    (FLIT_W=144, NUM_CH=2, DEPTH=4, LOCAL_RID=0).
module tb_hr_bridge_param;
   localparam int FW = 144;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   hr_bridge_param_if #(.FLIT_W(144), .NUM_CH(2), .DEPTH(4)) bus ();

   hr_bridge_param #(
      .FLIT_W(144), .NUM_CH(2), .DEPTH(4),
      .RID_W(4), .RID_LSB(4), .LOCAL_RID(0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   // Valid flit with destination ring id and a tag in the payload
   function automatic logic [FW-1:0] mk(input logic [3:0] dst, input logic [15:0] tag);
      logic [FW-1:0] f;
      f          = '0;
      f[0]       = 1'b1;
      f[7:4]     = dst;
      f[31:16]   = tag;
      f[143:128] = ~tag;
      return f;
   endfunction

   function automatic logic [FW-1:0] slot(input logic [2*FW-1:0] v, input int c);
      return v[c*FW +: FW];
   endfunction

   function automatic logic [2:0] cnt(input logic [5:0] v, input int c);
      return v[c*3 +: 3];
   endfunction

   task automatic set_loc(input int c, input logic [FW-1:0] f);
      bus.loc_i[c*FW +: FW] = f;
   endtask

   task automatic set_glb(input int c, input logic [FW-1:0] f);
      bus.glb_i[c*FW +: FW] = f;
   endtask

   task automatic idle();
      bus.loc_i = '0;
      bus.glb_i = '0;
   endtask

   // Advance one edge and settle; outputs then reflect the inputs just driven
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.loc_i = {mk(4'd3, 16'h1111), mk(4'd0, 16'h2222)};
      bus.glb_i = {mk(4'd0, 16'h3333), mk(4'd7, 16'h4444)};
      step();
      step();
      checks++;
      if (bus.loc_o !== '0) begin
         failures++;
         $display("[TB] FAIL reset_loc_o got=%h exp=0", bus.loc_o);
      end
      checks++;
      if (bus.glb_o !== '0) begin
         failures++;
         $display("[TB] FAIL reset_glb_o got=%h exp=0", bus.glb_o);
      end
      checks++;
      if (bus.l2g_cnt_o !== 6'd0 || bus.g2l_cnt_o !== 6'd0) begin
         failures++;
         $display("[TB] FAIL reset_cnt got l2g=%h g2l=%h exp=0", bus.l2g_cnt_o, bus.g2l_cnt_o);
      end
      checks++;
      if (bus.defl_l_o !== 16'd0 || bus.defl_g_o !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_defl got l=%0d g=%0d exp=0", bus.defl_l_o, bus.defl_g_o);
      end
      idle();
      rst = 1'b0;
      step();
   endtask

   task automatic test_cross();
      logic [FW-1:0] f;
      f = mk(4'd1, 16'hC001);
      set_loc(0, f);
      step();
      checks++;
      if (slot(bus.loc_o, 0) !== '0 || cnt(bus.l2g_cnt_o, 0) !== 3'd1) begin
         failures++;
         $display("[TB] FAIL cross_eject got loc_o=%h cnt=%0d exp loc_o=0 cnt=1",
                  slot(bus.loc_o, 0), cnt(bus.l2g_cnt_o, 0));
      end
      checks++;
      if (slot(bus.glb_o, 0) !== '0) begin
         failures++;
         $display("[TB] FAIL cross_no_bypass got=%h exp=0", slot(bus.glb_o, 0));
      end
      idle();
      step();
      checks++;
      if (slot(bus.glb_o, 0) !== f || cnt(bus.l2g_cnt_o, 0) !== 3'd0) begin
         failures++;
         $display("[TB] FAIL cross_inject got glb_o=%h cnt=%0d exp glb_o=%h cnt=0",
                  slot(bus.glb_o, 0), cnt(bus.l2g_cnt_o, 0), f);
      end
   endtask

   task automatic test_pass();
      logic [FW-1:0] g, l;
      g = mk(4'd5, 16'hBA55);
      l = mk(4'd0, 16'hCA11);
      set_glb(1, g);
      set_loc(1, l);
      step();
      checks++;
      if (slot(bus.glb_o, 1) !== g) begin
         failures++;
         $display("[TB] FAIL pass_glb got=%h exp=%h", slot(bus.glb_o, 1), g);
      end
      checks++;
      if (slot(bus.loc_o, 1) !== l) begin
         failures++;
         $display("[TB] FAIL pass_loc got=%h exp=%h", slot(bus.loc_o, 1), l);
      end
      checks++;
      if (bus.g2l_cnt_o !== 6'd0 || bus.l2g_cnt_o !== 6'd0) begin
         failures++;
         $display("[TB] FAIL pass_cnt got g2l=%h l2g=%h exp=0", bus.g2l_cnt_o, bus.l2g_cnt_o);
      end
      idle();
      step();
   endtask

   task automatic test_full_deflect();
      logic [FW-1:0] lf;
      for (int k = 1; k <= 5; k++) begin
         set_glb(0, mk(4'd5, 16'h5000 + 16'(k)));
         lf = mk(4'd1, 16'hF000 + 16'(k));
         set_loc(0, lf);
         step();
         if (k < 5) begin
            checks++;
            if (slot(bus.loc_o, 0) !== '0 || cnt(bus.l2g_cnt_o, 0) !== 3'(k)) begin
               failures++;
               $display("[TB] FAIL full_fill%0d got loc_o=%h cnt=%0d exp loc_o=0 cnt=%0d",
                        k, slot(bus.loc_o, 0), cnt(bus.l2g_cnt_o, 0), k);
            end
         end
      end
      checks++;
      if (slot(bus.loc_o, 0) !== lf || bus.defl_l_o !== 16'd1 || cnt(bus.l2g_cnt_o, 0) !== 3'd4) begin
         failures++;
         $display("[TB] FAIL full_deflect got loc_o=%h defl=%0d cnt=%0d exp loc_o=%h defl=1 cnt=4",
                  slot(bus.loc_o, 0), bus.defl_l_o, cnt(bus.l2g_cnt_o, 0), lf);
      end
      checks++;
      if (slot(bus.glb_o, 0) !== mk(4'd5, 16'h5005)) begin
         failures++;
         $display("[TB] FAIL full_glb_pass got=%h exp=%h", slot(bus.glb_o, 0), mk(4'd5, 16'h5005));
      end
      idle();
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (slot(bus.glb_o, 0) !== mk(4'd1, 16'hF000 + 16'(k)) || cnt(bus.l2g_cnt_o, 0) !== 3'(4 - k)) begin
            failures++;
            $display("[TB] FAIL full_drain%0d got glb_o=%h cnt=%0d exp glb_o=%h cnt=%0d",
                     k, slot(bus.glb_o, 0), cnt(bus.l2g_cnt_o, 0), mk(4'd1, 16'hF000 + 16'(k)), 4 - k);
         end
      end
   endtask

   task automatic test_multi_defl();
      for (int k = 1; k <= 5; k++) begin
         set_glb(0, mk(4'd5, 16'h6000));
         set_glb(1, mk(4'd5, 16'h6100));
         set_loc(0, mk(4'd1, 16'hA000 + 16'(k)));
         set_loc(1, mk(4'd2, 16'hB000 + 16'(k)));
         step();
      end
      checks++;
      if (bus.defl_l_o !== 16'd3 || bus.l2g_cnt_o !== {3'd4, 3'd4}) begin
         failures++;
         $display("[TB] FAIL multi_defl got defl=%0d cnt=%h exp defl=3 cnt=24", bus.defl_l_o, bus.l2g_cnt_o);
      end
      checks++;
      if (slot(bus.loc_o, 0) !== mk(4'd1, 16'hA005) || slot(bus.loc_o, 1) !== mk(4'd2, 16'hB005)) begin
         failures++;
         $display("[TB] FAIL multi_defl_loc got ch0=%h ch1=%h", slot(bus.loc_o, 0), slot(bus.loc_o, 1));
      end
      idle();
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (slot(bus.glb_o, 1) !== mk(4'd2, 16'hB000 + 16'(k))) begin
            failures++;
            $display("[TB] FAIL multi_drain%0d got=%h exp=%h", k, slot(bus.glb_o, 1), mk(4'd2, 16'hB000 + 16'(k)));
         end
      end
      checks++;
      if (bus.l2g_cnt_o !== 6'd0) begin
         failures++;
         $display("[TB] FAIL multi_empty got=%h exp=0", bus.l2g_cnt_o);
      end
   endtask

   task automatic test_simultaneous();
      logic [FW-1:0] g5;
      for (int k = 1; k <= 4; k++) begin
         set_glb(0, mk(4'd0, 16'hD000 + 16'(k)));
         set_loc(0, mk(4'd0, 16'hE000 + 16'(k)));
         step();
      end
      checks++;
      if (cnt(bus.g2l_cnt_o, 0) !== 3'd4 || slot(bus.loc_o, 0) !== mk(4'd0, 16'hE004)) begin
         failures++;
         $display("[TB] FAIL simul_fill got cnt=%0d loc_o=%h exp cnt=4 loc_o=%h",
                  cnt(bus.g2l_cnt_o, 0), slot(bus.loc_o, 0), mk(4'd0, 16'hE004));
      end
      g5 = mk(4'd0, 16'hD005);
      set_loc(0, '0);
      set_glb(0, g5);
      step();
      checks++;
      if (slot(bus.loc_o, 0) !== mk(4'd0, 16'hD001)) begin
         failures++;
         $display("[TB] FAIL simul_inject got=%h exp=%h", slot(bus.loc_o, 0), mk(4'd0, 16'hD001));
      end
      checks++;
      if (slot(bus.glb_o, 0) !== g5 || bus.defl_g_o !== 16'd1 || cnt(bus.g2l_cnt_o, 0) !== 3'd3) begin
         failures++;
         $display("[TB] FAIL simul_deflect got glb_o=%h defl=%0d cnt=%0d exp glb_o=%h defl=1 cnt=3",
                  slot(bus.glb_o, 0), bus.defl_g_o, cnt(bus.g2l_cnt_o, 0), g5);
      end
      idle();
      for (int k = 2; k <= 4; k++) begin
         step();
         checks++;
         if (slot(bus.loc_o, 0) !== mk(4'd0, 16'hD000 + 16'(k)) || cnt(bus.g2l_cnt_o, 0) !== 3'(4 - k)) begin
            failures++;
            $display("[TB] FAIL simul_drain%0d got loc_o=%h cnt=%0d exp loc_o=%h cnt=%0d",
                     k, slot(bus.loc_o, 0), cnt(bus.g2l_cnt_o, 0), mk(4'd0, 16'hD000 + 16'(k)), 4 - k);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [FW-1:0] exp_f;
      for (int k = 1; k <= 10; k++) begin
         if (k <= 9) set_loc(1, mk(4'd9, 16'h7000 + 16'(k)));
         else        idle();
         step();
         exp_f = (k == 1) ? '0 : mk(4'd9, 16'h7000 + 16'(k - 1));
         checks++;
         if (slot(bus.glb_o, 1) !== exp_f || cnt(bus.l2g_cnt_o, 1) !== ((k <= 9) ? 3'd1 : 3'd0)) begin
            failures++;
            $display("[TB] FAIL stream%0d got glb_o=%h cnt=%0d exp glb_o=%h cnt=%0d",
                     k, slot(bus.glb_o, 1), cnt(bus.l2g_cnt_o, 1), exp_f, (k <= 9) ? 1 : 0);
         end
      end
      checks++;
      if (bus.defl_l_o !== 16'd3 || bus.defl_g_o !== 16'd1) begin
         failures++;
         $display("[TB] FAIL final_defl got l=%0d g=%0d exp l=3 g=1", bus.defl_l_o, bus.defl_g_o);
      end
   endtask

   initial begin
      bus.loc_i = '0;
      bus.glb_i = '0;
      test_reset();
      test_cross();
      test_pass();
      test_full_deflect();
      test_multi_defl();
      test_simultaneous();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
